// File: rtl/booth_ctrl.sv
// Control sequencer for a radix-2 Booth multiplier (A/M/Q registers + add/sub unit).
// Optional macro BOOTH_CYCLE_CNT_EN adds the 8-bit 'cycles' operation-length report.
module booth_ctrl #(
   parameter int N  = 4,
   parameter int CW = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       q0,
   input  logic       q_1,
   output logic       carga_m,
   output logic       carga_q,
   output logic       clr_a,
   output logic       carga_a,
   output logic       resta,
   output logic       desplaza,
   output logic       busy,
   output logic       done
`ifdef BOOTH_CYCLE_CNT_EN
   ,output logic [7:0] cycles
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_TEST, S_ADD, S_SHIFT, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          resta_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      resta_d = 1'b0;
      case (state_q)
         S_IDLE:  if (start) state_d = S_LOAD;
         S_LOAD: begin
            cnt_d   = CW'(N);
            state_d = S_TEST;
         end
         S_TEST: begin
            case ({q0, q_1})
               2'b01:   state_d = S_ADD;
               2'b10: begin
                  state_d = S_ADD;
                  resta_d = 1'b1;
               end
               default: state_d = S_SHIFT;
            endcase
         end
         S_ADD:   state_d = S_SHIFT;
         S_SHIFT: begin
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? S_DONE : S_TEST;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every strobe is a flop (Moore, registered).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         carga_m  <= 1'b0;
         carga_q  <= 1'b0;
         clr_a    <= 1'b0;
         carga_a  <= 1'b0;
         resta    <= 1'b0;
         desplaza <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carga_m  <= (state_d == S_LOAD);
         carga_q  <= (state_d == S_LOAD);
         clr_a    <= (state_d == S_LOAD);
         carga_a  <= (state_d == S_ADD);
         resta    <= resta_d;
         desplaza <= (state_d == S_SHIFT);
         busy     <= (state_d != S_IDLE);
         done     <= (state_d == S_DONE);
      end
   end

`ifdef BOOTH_CYCLE_CNT_EN
   logic [7:0] cyc_q, cyc_d, cycles_d;

   // cyc_q reads k-1 in the k-th busy cycle; the DONE snapshot is the op length minus one.
   always_comb begin
      cyc_d    = cyc_q;
      cycles_d = cycles;
      if (state_d == S_LOAD)
         cyc_d = '0;
      else if (state_q != S_IDLE && cyc_q != 8'hFF)
         cyc_d = cyc_q + 8'd1;
      if (state_d == S_DONE)
         cycles_d = cyc_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc_q  <= '0;
         cycles <= '0;
      end else begin
         cyc_q  <= cyc_d;
         cycles <= cycles_d;
      end
   end
`endif

endmodule
